uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_receiver.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry, line levels,
// receiver state encoding and a 2-of-3 vote helper.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to the idle line level so reset never looks like a start bit.
import uart_pkg::*;

module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw line through two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on a 16x oversampling clock, LSB first.
// Optional macro UART_RX_MAJORITY_EN: start/data/stop decisions use the
// 2-of-3 majority of the synchronised line over the decision tick and the
// two ticks before it; otherwise a single sample at the decision tick.
import uart_pkg::*;

module uart_receiver #(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 sampleclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_STATUS,
  output logic                 FRAME_ERR,
  output logic                 RX_BUSY
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_sample;

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_status;
  logic                 w_status_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;

  uart_rx_sync u_sync (
    .i_clk   (sampleclk),
    .i_rst_n (reset),
    .i_async (UART_RX),
    .o_sync  (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Keep the two previous synchronised samples for the majority vote.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      r_hist <= '1;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = maj3(w_rx_s, r_hist[0], r_hist[1]);
`else
  assign w_sample = w_rx_s;
`endif

  // Register FSM state, counters, shift register and output strobes.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_status <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_status <= w_status_nxt;
      r_ferr   <= w_ferr_nxt;
    end
  end

  // Next-state and datapath decisions; strobes default low every cycle.
  // Bits enter at the MSB and shift right, so after DATA_BITS shifts the
  // first-received bit sits at bit 0 (LSB-first without a variable index).
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_status_nxt = 1'b0;
    w_ferr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s == LINE_START) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          if (w_sample == LINE_START) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_sample, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_sample == LINE_STOP) begin
            w_data_nxt   = r_shift;
            w_status_nxt = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_BRK_WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_BRK_WAIT: begin
        w_cnt_nxt = '0;
        if (w_rx_s == LINE_IDLE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign RX_DATA   = r_data;
  assign RX_STATUS = r_status;
  assign FRAME_ERR = r_ferr;
  assign RX_BUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. Line waveforms are built as one
// level per sampleclk tick; expected bytes come from mid-bit sampling of
// that waveform (offset 24+16*i from the start edge, stop at 152).
module tb_uart_receiver;

  logic       sampleclk = 1'b0;
  logic       reset     = 1'b0;
  logic       UART_RX   = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       FRAME_ERR;
  logic       RX_BUSY;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .sampleclk (sampleclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .FRAME_ERR (FRAME_ERR),
    .RX_BUSY   (RX_BUSY)
  );

  always #5 sampleclk = ~sampleclk;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;
  bit         wave[$];
  int         status_cyc[$];
  logic [7:0] status_dat[$];
  int         ferr_cyc[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge sampleclk) cyc <= cyc + 1;

  always @(negedge sampleclk) begin
    if (RX_STATUS === 1'b1) begin
      status_cyc.push_back(cyc);
      status_dat.push_back(RX_DATA);
    end
    if (FRAME_ERR === 1'b1) ferr_cyc.push_back(cyc);
    if (RX_STATUS === 1'b1 && FRAME_ERR === 1'b1) both_cnt++;
    if (RX_BUSY === 1'b1) busy_cnt++;
  end

  task automatic add_level(input bit lv, input int n);
    for (int k = 0; k < n; k++) wave.push_back(lv);
  endtask

  // Start, 8 data bits LSB first, stop. Jitter alternates 15/17-tick cells.
  task automatic add_frame(input logic [7:0] data, input bit stop, input bit jitter);
    logic [7:0] sh;
    sh = data;
    for (int k = 0; k < 10; k++) begin
      bit lv;
      int len;
      if (k == 0) lv = 1'b0;
      else if (k == 9) lv = stop;
      else begin
        lv = sh[0];
        sh = sh >> 1;
      end
      len = jitter ? ((k % 2 == 0) ? 15 : 17) : 16;
      add_level(lv, len);
    end
  endtask

  function automatic bit line_at(input int idx);
    if (idx < 0 || idx >= wave.size()) return 1'b1;
    return wave[idx];
  endfunction

  function automatic bit decide(input int idx);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(line_at(idx)) + int'(line_at(idx - 1)) + int'(line_at(idx - 2));
    return (ones >= 2);
`else
    return line_at(idx);
`endif
  endfunction

  task automatic model_frame(input int s, output logic [7:0] d, output bit stop);
    d = 8'h00;
    for (int i = 0; i < 8; i++) d = {decide(s + 24 + 16 * i), d[7:1]};
    stop = decide(s + 152);
  endtask

  task automatic clear_logs();
    status_cyc.delete();
    status_dat.delete();
    ferr_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic play_wave(output int base);
    base = 0;
    for (int k = 0; k < wave.size(); k++) begin
      @(negedge sampleclk);
      if (k == 0) base = cyc;
      UART_RX = wave[k];
    end
    repeat (4) @(negedge sampleclk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    UART_RX = 1'b1;
    repeat (3) @(negedge sampleclk);
    vectors++;
    if ({RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got %h %b %b %b want 00 0 0 0", RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY);
    end
    reset = 1'b1;
    repeat (5) @(negedge sampleclk);
    vectors++;
    if (RX_BUSY !== 1'b0 || RX_STATUS !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset busy=%b status=%b want 0 0", RX_BUSY, RX_STATUS);
    end
  endtask

  task automatic test_single();
    int s, base;
    logic [7:0] d;
    bit stp;
    wave.delete();
    add_level(1'b1, 10);
    s = wave.size();
    add_frame(8'hA5, 1'b1, 1'b0);
    add_level(1'b1, 20);
    model_frame(s, d, stp);
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL a5_pulse_count got %0d want 1", status_cyc.size());
    end else begin
      vectors++;
      if (status_dat[0] !== d || d !== 8'hA5) begin
        miscompares++;
        $display("FAIL a5_data got %h want %h", status_dat[0], d);
      end
      vectors++;
      if (status_cyc[0] != base + s + 155) begin
        miscompares++;
        $display("FAIL a5_latency got %0d want %0d", status_cyc[0], base + s + 155);
      end
    end
    vectors++;
    if (ferr_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL a5_ferr got %0d pulses want 0", ferr_cyc.size());
    end
    last_good = d;
    vectors++;
    if (RX_DATA !== last_good || RX_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_hold data=%h busy=%b want %h 0", RX_DATA, RX_BUSY, last_good);
    end
  endtask

  task automatic test_back_to_back();
    int s0, s1, base;
    wave.delete();
    add_level(1'b1, 10);
    s0 = wave.size();
    add_frame(8'h00, 1'b1, 1'b0);
    s1 = wave.size();
    add_frame(8'hFF, 1'b1, 1'b0);
    add_level(1'b1, 20);
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_pulse_count got %0d want 2", status_cyc.size());
    end else begin
      vectors++;
      if (status_dat[0] !== 8'h00 || status_dat[1] !== 8'hFF) begin
        miscompares++;
        $display("FAIL b2b_data got %h %h want 00 ff", status_dat[0], status_dat[1]);
      end
      vectors++;
      if (status_cyc[1] - status_cyc[0] != s1 - s0 || status_cyc[0] != base + s0 + 155) begin
        miscompares++;
        $display("FAIL b2b_spacing got %0d want %0d", status_cyc[1] - status_cyc[0], 160);
      end
    end
    last_good = 8'hFF;
  endtask

  task automatic test_random();
    int starts[$];
    logic [7:0] exp_d[$];
    int base;
    logic [7:0] d;
    bit stp;
    wave.delete();
    add_level(1'b1, 8);
    for (int f = 0; f < 6; f++) begin
      starts.push_back(wave.size());
      add_frame(8'($urandom), 1'b1, 1'b0);
      add_level(1'b1, $urandom_range(0, 12));
    end
    add_level(1'b1, 20);
    foreach (starts[f]) begin
      model_frame(starts[f], d, stp);
      exp_d.push_back(d);
    end
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != starts.size()) begin
      miscompares++;
      $display("FAIL rand_pulse_count got %0d want %0d", status_cyc.size(), starts.size());
    end else begin
      foreach (starts[f]) begin
        vectors++;
        if (status_dat[f] !== exp_d[f] || status_cyc[f] != base + starts[f] + 155) begin
          miscompares++;
          $display("FAIL rand_frame%0d got %h@%0d want %h@%0d", f, status_dat[f], status_cyc[f],
                   exp_d[f], base + starts[f] + 155);
        end
      end
    end
    last_good = exp_d[exp_d.size() - 1];
  endtask

  task automatic test_glitch();
    int base;
    wave.delete();
    add_level(1'b1, 10);
    add_level(1'b0, 4);
    add_level(1'b1, 30);
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 0 || ferr_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_pulses got %0d status %0d ferr want 0 0", status_cyc.size(), ferr_cyc.size());
    end
    vectors++;
    if (busy_cnt < 1 || busy_cnt > 10) begin
      miscompares++;
      $display("FAIL glitch_busy got %0d cycles want 1..10", busy_cnt);
    end
    vectors++;
    if (RX_DATA !== last_good) begin
      miscompares++;
      $display("FAIL glitch_data got %h want %h", RX_DATA, last_good);
    end
  endtask

  task automatic test_frame_err();
    int s, base;
    logic [7:0] d;
    bit stp;
    wave.delete();
    add_level(1'b1, 10);
    s = wave.size();
    add_frame(8'h3C, 1'b0, 1'b0);
    add_level(1'b0, 40 * 16);
    model_frame(s, d, stp);
    clear_logs();
    play_wave(base);
    vectors++;
    if (ferr_cyc.size() != (stp ? 0 : 1) || status_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL ferr_count got %0d ferr %0d status want 1 0", ferr_cyc.size(), status_cyc.size());
    end else begin
      vectors++;
      if (ferr_cyc[0] != base + s + 155) begin
        miscompares++;
        $display("FAIL ferr_latency got %0d want %0d", ferr_cyc[0], base + s + 155);
      end
    end
    vectors++;
    if (RX_DATA !== last_good || RX_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL break_hold data=%h busy=%b want %h 1", RX_DATA, RX_BUSY, last_good);
    end
    wave.delete();
    add_level(1'b1, 20);
    s = wave.size();
    add_frame(8'h81, 1'b1, 1'b0);
    add_level(1'b1, 20);
    model_frame(s, d, stp);
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 1 || ferr_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL after_break_count got %0d status %0d ferr want 1 0", status_cyc.size(), ferr_cyc.size());
    end else begin
      vectors++;
      if (status_dat[0] !== d || d !== 8'h81) begin
        miscompares++;
        $display("FAIL after_break_data got %h want %h", status_dat[0], d);
      end
    end
    last_good = d;
  endtask

  task automatic test_mid_reset();
    int s, base;
    logic [7:0] d;
    bit stp;
    wave.delete();
    add_level(1'b1, 10);
    s = wave.size();
    add_frame(8'hC3, 1'b1, 1'b0);
    while (wave.size() > s + 88) void'(wave.pop_back());
    clear_logs();
    play_wave(base);
    vectors++;
    if (RX_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy got %b want 1", RX_BUSY);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY} !== 11'h000) begin
      miscompares++;
      $display("FAIL async_reset got %h %b %b %b want 00 0 0 0", RX_DATA, RX_STATUS, FRAME_ERR, RX_BUSY);
    end
    last_good = 8'h00;
    UART_RX = 1'b1;
    repeat (3) @(negedge sampleclk);
    reset = 1'b1;
    wave.delete();
    add_level(1'b1, 10);
    s = wave.size();
    add_frame(8'h5A, 1'b1, 1'b0);
    add_level(1'b1, 20);
    model_frame(s, d, stp);
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 1 || ferr_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_count got %0d status %0d ferr want 1 0", status_cyc.size(), ferr_cyc.size());
    end else begin
      vectors++;
      if (status_dat[0] !== d || d !== 8'h5A || status_cyc[0] != base + s + 155) begin
        miscompares++;
        $display("FAIL post_reset_frame got %h@%0d want %h@%0d", status_dat[0], status_cyc[0], d, base + s + 155);
      end
    end
    last_good = d;
  endtask

  task automatic test_skew_spike();
    int s, base;
    logic [7:0] d, want;
    bit stp;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h96;
`else
    want = 8'h92;
`endif
    wave.delete();
    add_level(1'b1, 10);
    s = wave.size();
    add_frame(8'h96, 1'b1, 1'b1);
    add_level(1'b1, 20);
    wave[s + 24 + 16 * 2] = ~wave[s + 24 + 16 * 2];
    model_frame(s, d, stp);
    clear_logs();
    play_wave(base);
    vectors++;
    if (status_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL skew_pulse_count got %0d want 1", status_cyc.size());
    end else begin
      vectors++;
      if (status_dat[0] !== want || status_dat[0] !== d) begin
        miscompares++;
        $display("FAIL skew_data got %h want %h", status_dat[0], want);
      end
    end
    last_good = want;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_skew_spike();
    vectors++;
    if (both_cnt != 0) begin
      miscompares++;
      $display("FAIL status_and_ferr_together got %0d cycles want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
